// File: rtl/cone_cmp_pkg.sv
// Shared constants and state encoding for the cone response compactor.
package cone_cmp_pkg;

  localparam int unsigned CONE_DATA_W = 8;
  localparam int unsigned CONE_SIG_W  = 16;
  localparam logic [15:0] CONE_POLY   = 16'h1021;

  // Bit positions of the cone outputs inside a response vector.
  localparam int unsigned N6_BIT  = 0;
  localparam int unsigned N9_BIT  = 1;
  localparam int unsigned N42_BIT = 2;
  localparam int unsigned N48_BIT = 3;
  localparam int unsigned N56_BIT = 4;
  localparam int unsigned N65_BIT = 5;
  localparam int unsigned N68_BIT = 6;
  localparam int unsigned N77_BIT = 7;

  typedef enum logic [1:0] {
    CmpIdle = 2'd0,
    CmpRun  = 2'd1,
    CmpDone = 2'd2
  } cmp_state_e;

endpackage

// File: rtl/cone_response_compactor_if.sv
// Response-in / raw-vector-out handshake bundle of the compactor.
interface cone_response_compactor_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/cone_resp_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered head word.
module cone_resp_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] head_q, head_d;
  logic              do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = head_q;

  always_comb begin
    wr_d   = wr_q + (AW + 1)'(do_push);
    rd_d   = rd_q + (AW + 1)'(do_pop);
    head_d = head_q;
    // The pushed word becomes the head when it lands in the slot the read pointer will address.
    if (do_push && (wr_q == rd_d)) begin
      head_d = push_data_i;
    end else if (do_pop) begin
      head_d = mem_q[rd_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= push_data_i;
      end
    end
  end
endmodule

// File: rtl/cone_response_compactor.sv
// Capture stage: buffers cone responses and folds them into a MISR signature.
// Optional golden-signature comparator enabled by CONE_CMP_GOLDEN_EN.
module cone_response_compactor
  import cone_cmp_pkg::*;
#(
  parameter int unsigned      DATA_W = CONE_DATA_W,
  parameter int unsigned      SIG_W  = CONE_SIG_W,
  parameter int unsigned      DEPTH  = 4,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(CONE_POLY)
) (
  input  logic                       clk,
  input  logic                       rst,
  cone_response_compactor_if.slave   bus,
  input  logic                       start_i,
  input  logic [15:0]                vec_total_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [SIG_W-1:0]           signature_o,
  input  logic [SIG_W-1:0]           golden_i,
  output logic                       sig_pass_o
);
  localparam logic [1:0] StIdle = 2'(CmpIdle);
  localparam logic [1:0] StRun  = 2'(CmpRun);
  localparam logic [1:0] StDone = 2'(CmpDone);

  logic [1:0]       state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      total_q, total_d;
  logic             fifo_full, fifo_empty, accept;

  assign busy_o        = (state_q == StRun);
  assign done_o        = (state_q == StDone);
  assign signature_o   = sig_q;
  assign bus.in_ready  = busy_o && !fifo_full;
  assign bus.out_valid = !fifo_empty;
  assign accept        = bus.in_valid && bus.in_ready;

  cone_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (accept),
    .push_data_i (bus.in_data),
    .pop_i       (bus.out_ready),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (bus.out_data)
  );

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    // start wins over a same-cycle accept: the run restarts from a clean signature.
    if (start_i) begin
      sig_d   = '0;
      cnt_d   = '0;
      total_d = vec_total_i;
      state_d = (vec_total_i != 16'd0) ? StRun : StDone;
    end else if (accept) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ SIG_W'(bus.in_data);
      cnt_d = cnt_q + 16'd1;
      if (cnt_d == total_q) begin
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sig_q   <= '0;
      cnt_q   <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
    end
  end

`ifdef CONE_CMP_GOLDEN_EN
  logic pass_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q <= 1'b0;
    end else if (start_i) begin
      pass_q <= 1'b0;
    end else if (state_q == StDone) begin
      pass_q <= (sig_q == golden_i);
    end
  end

  assign sig_pass_o = pass_q;
`else
  logic unused_golden;
  assign unused_golden = ^golden_i;
  assign sig_pass_o    = 1'b0;
`endif
endmodule

// File: doc/cone_response_compactor.md
# cone_response_compactor

Downstream capture stage for the 8-output combinational cone `top_809960632_810038711_1598227639_893650103`. It accepts one 8-bit response vector per handshake and buffers the raw vectors in a small FIFO for readback. It also folds every accepted vector into a 16-bit MISR signature. A bounded run of `vec_total` vectors produces a final signature for equivalence checking of the optimised netlist.

## Interface
Parameters:
- `DATA_W`, 8, response width; bit order {n77,n68,n65,n56,n48,n42,n9,n6}, n6 = bit 0
- `SIG_W`, 16, signature width
- `DEPTH`, 4, raw FIFO entries; must be a power of two, ≥2
- `POLY`, 16'h1021, MISR feedback polynomial

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a run
- `vec_total`  in  16  vectors per run; sampled on `start`
- `in_valid`  in  1  response vector present
- `in_data`  in  DATA_W  cone response
- `in_ready`  out  1  vector accepted when `in_valid && in_ready`
- `out_valid`  out  1  FIFO head valid
- `out_data`  out  DATA_W  FIFO head
- `out_ready`  in  1  pop when `out_valid && out_ready`
- `busy`  out  1  state == RUN
- `done`  out  1  state == DONE
- `signature`  out  SIG_W  current MISR value
- `golden`  in  SIG_W  expected signature (see Configuration)
- `sig_pass`  out  1  final signature matches `golden`

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on `start` with `vec_total != 0`.
  - IDLE→DONE on `start` with `vec_total == 0`.
  - RUN→DONE on acceptance of vector number `vec_total`.
  - DONE→RUN or DONE→DONE on `start`, using the same rule as from IDLE.
- `start` clears the signature and the accepted count to 0 and latches `vec_total`. `start` in RUN aborts the current run and restarts identically. FIFO contents are never cleared by `start`.
- `in_ready = busy && !fifo_full`. There is no push-through when full, even with a simultaneous pop.
- On accept: the vector is pushed into the FIFO, the count increments, and the signature updates as sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extend(in_data).
- FIFO:
  - Circular pointers with one extra wrap bit; full and empty are derived from the pointers.
  - Simultaneous push and pop when not full and not empty: occupancy is unchanged.
  - Push and pop on the same cycle when empty: the push lands, there is no bypass, and `out_valid` rises the next cycle.
- The FIFO drains in any state, including IDLE and DONE.
- `in_valid` while not busy is ignored; `in_ready` = 0.

## Timing
- Reset values: state IDLE, `in_ready` 0, `out_valid` 0, `out_data` 0, `busy` 0, `done` 0, `signature` 0, `sig_pass` 0, count 0, FIFO empty.
- Reset mid-run discards all state immediately.
- Handshake to signature latency: 1 cycle. `signature` reflects the accepted vector on the cycle after the handshake.
- `done` rises the same cycle the signature includes the final vector.
- `busy`/`in_ready` rise 1 cycle after `start`.
- `out_data` is registered from FIFO storage. It is stable while `out_valid && !out_ready`.

## Configuration
- `CONE_CMP_GOLDEN_EN` defined:
  - A registered comparator sets `sig_pass` = (signature == `golden`) while DONE.
  - `sig_pass` is updated every cycle in DONE and cleared on `start`.
- Not defined:
  - `golden` is ignored and `sig_pass` is tied to 0.
  - No comparator logic is synthesised.

## Structure
- Shared package `cone_cmp_pkg`:
  - state enum `cmp_state_e`
  - `CONE_DATA_W` = 8, `CONE_SIG_W` = 16, `CONE_POLY` = 16'h1021
  - bit-index constants for the eight cone outputs
- One sub-module: `cone_resp_fifo`, a parameterised synchronous FIFO with push/pop, full/empty and registered head.
- MISR, counter and FSM live in the top.

## Test plan
- Reset, then `start` with `vec_total`=1 and send 0x5A: `done`=1 the next cycle, `signature`=0x005A, `out_data`=0x5A with `out_valid`=1.
- `vec_total`=2, send 0x01 then 0x00: signature 0x0001 then 0x0002, `done` after the second accept.
- Overflow: force a run reaching sig 0x8000, then accept 0x00 → `signature`=0x1021.
- Hold `out_ready`=0 and send 5 vectors with `vec_total`=8: `in_ready` drops after 4 accepts. Pop one → exactly one more accept, FIFO order preserved.
- Edge cases:
  - `start` with `vec_total`=0 → DONE next cycle, signature 0.
  - `start` mid-run → signature and count reset, FIFO retains prior entries.
- With `CONE_CMP_GOLDEN_EN`, `golden`=0x005A and the single vector 0x5A → `sig_pass`=1. With `golden`=0x005B → 0. Without the macro → always 0.
